br_lite_local_injector: RTL and testbench

//  Local-port injector for the BrLite broadcast router: buffers PE broadcast requests in a FIFO,

---
 rtl/br_lite_local_injector.sv | 180 ++++++++++++++++++
 tb/tb_br_lite_local_injector.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_lite_local_injector.sv
// BrLite local-port injector: queues PE broadcast requests and presents them one at a
// time, stamped with source address and rolling id, on the router LOCAL req/ack port.

package br_lite_pkg;

  typedef enum logic [1:0] {
    BR_SVC_ALL   = 2'b00,
    BR_SVC_TGT   = 2'b01,
    BR_SVC_CLEAR = 2'b10,
    BR_SVC_RSV   = 2'b11
  } br_svc_t;

  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] target;
    logic [15:0] source;
    logic [15:0] producer;
    logic [7:0]  ksvc;
    logic [4:0]  id;
    br_svc_t     service;
  } br_data_t;

  // Queued request: source and id are stamped only when the packet is loaded
  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] target;
    logic [15:0] producer;
    logic [7:0]  ksvc;
    br_svc_t     service;
  } br_req_t;

endpackage

module br_lite_local_injector
  import br_lite_pkg::*;
#(
  parameter logic [15:0] ADDRESS    = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_service_i,
  input  logic [31:0]                 req_payload_i,
  input  logic [15:0]                 req_target_i,
  input  logic [15:0]                 req_producer_i,
  input  logic [7:0]                  req_ksvc_i,
  output logic                        br_req_o,
  input  logic                        br_ack_i,
  output logic [$bits(br_data_t)-1:0] br_data_o,
  output logic                        err_o,
  output logic [$clog2(FIFO_DEPTH):0] pending_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ID_W  = 5;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  state_t           state_q, state_d;
  br_req_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_d;
  logic [ID_W-1:0]  id_q, id_d;
  br_data_t         data_q, data_d;
  logic             br_req_d;
  logic             err_d;
  logic             ready_d;

  br_svc_t          svc_c;
  logic             svc_ok_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  br_req_t          push_entry_c;
  br_req_t          head_c;

  assign br_data_o = data_q;

  // Request side: only broadcast services are queued; CLEAR and the reserved code are rejected
  always_comb begin
    svc_c                 = br_svc_t'(req_service_i);
    svc_ok_c              = (svc_c == BR_SVC_ALL) || (svc_c == BR_SVC_TGT);
    accept_c              = req_valid_i && req_ready_o;
    push_c                = accept_c && svc_ok_c;
    err_d                 = accept_c && !svc_ok_c;
    push_entry_c.payload  = req_payload_i;
    push_entry_c.target   = req_target_i;
    push_entry_c.producer = req_producer_i;
    push_entry_c.ksvc     = req_ksvc_i;
    push_entry_c.service  = svc_c;
    head_c                = mem_q[rd_ptr_q];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    br_req_d = br_req_o;
    id_d     = id_q;
    pop_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_o != '0) begin
          pop_c            = 1'b1;
          data_d.payload   = head_c.payload;
          data_d.target    = head_c.target;
          data_d.source    = ADDRESS;
          data_d.producer  = head_c.producer;
          data_d.ksvc      = head_c.ksvc;
          data_d.id        = id_q;
          data_d.service   = head_c.service;
          br_req_d         = 1'b1;
          state_d          = ST_SEND;
        end
      end
      ST_SEND: begin
        if (br_req_o && br_ack_i) begin
          id_d     = id_q + ID_W'(1);
          br_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        br_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push_c, pop_c})
      2'b10:   count_d = pending_o + CNT_W'(1);
      2'b01:   count_d = pending_o - CNT_W'(1);
      default: count_d = pending_o;
    endcase

    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_o   <= '0;
      id_q        <= '0;
      data_q      <= '0;
      br_req_o    <= 1'b0;
      err_o       <= 1'b0;
      req_ready_o <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_o   <= count_d;
      id_q        <= id_d;
      data_q      <= data_d;
      br_req_o    <= br_req_d;
      err_o       <= err_d;
      req_ready_o <= ready_d;
    end
  end

  // Payload storage needs no reset: occupancy alone qualifies every read
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= push_entry_c;
    end
  end

endmodule

// File: tb/tb_br_lite_local_injector.sv
// Randomized self-checking bench for br_lite_local_injector against an in-order packet model.

module tb_br_lite_local_injector;
  import br_lite_pkg::*;

  localparam logic [15:0] ADDR  = 16'h0102;
  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_service;
  logic [31:0] req_payload;
  logic [15:0] req_target;
  logic [15:0] req_producer;
  logic [7:0]  req_ksvc;
  logic        br_req;
  logic        br_ack;
  br_data_t    br_data;
  logic        err;
  logic [2:0]  pending;

  br_lite_local_injector #(
    .ADDRESS    (ADDR),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_service_i  (req_service),
    .req_payload_i  (req_payload),
    .req_target_i   (req_target),
    .req_producer_i (req_producer),
    .req_ksvc_i     (req_ksvc),
    .br_req_o       (br_req),
    .br_ack_i       (br_ack),
    .br_data_o      (br_data),
    .err_o          (err),
    .pending_o      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       n_checks = 0;
  int       n_pass   = 0;
  int       cyc      = 0;
  int       ack_mode = 0;   // 0: ack low, 1: ack tied high, 2: random delay 0-3
  int       ack_wait = -1;
  int       m_next_id = 0;
  br_data_t exp_q[$];
  br_data_t rx_q[$];
  int       rx_cyc[$];
  logic     prev_req = 1'b0;
  br_data_t prev_data = '0;

  // Router model: drives ack and records every packet accepted at the next edge
  always @(negedge clk) begin
    case (ack_mode)
      0: br_ack = 1'b0;
      1: br_ack = 1'b1;
      default: begin
        if (!br_req) begin
          ack_wait = -1;
          br_ack   = 1'($urandom_range(0, 1));
        end else begin
          if (ack_wait < 0) ack_wait = int'($urandom_range(0, 3));
          if (ack_wait == 0) br_ack = 1'b1;
          else begin
            br_ack = 1'b0;
            ack_wait--;
          end
        end
      end
    endcase
    if (rst_n && br_req && br_ack) begin
      rx_q.push_back(br_data);
      rx_cyc.push_back(cyc);
    end
  end

  // Packet must hold while offered and not yet acknowledged
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst_n && prev_req && !br_ack) begin
      n_checks++;
      if (br_req !== 1'b1 || br_data !== prev_data)
        $display("FAIL hold_stable @%0d: req=%b data=%h, required req=1 data=%h",
                 cyc, br_req, br_data, prev_data);
      else n_pass++;
    end
    prev_req  = br_req;
    prev_data = br_data;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Expected packet stream: accepted broadcast requests in order, id = acceptance index mod 32
  function automatic void model_accept(input logic [1:0] svc, input logic [31:0] pl,
                                       input logic [15:0] tg, input logic [15:0] pr,
                                       input logic [7:0] ks);
    br_data_t p;
    if (svc == BR_SVC_ALL || svc == BR_SVC_TGT) begin
      p.payload  = pl;
      p.target   = tg;
      p.source   = ADDR;
      p.producer = pr;
      p.ksvc     = ks;
      p.id       = 5'(m_next_id % 32);
      p.service  = br_svc_t'(svc);
      exp_q.push_back(p);
      m_next_id++;
    end
  endfunction

  task automatic drive_idle();
    req_valid    = 1'b0;
    req_service  = 2'b00;
    req_payload  = '0;
    req_target   = '0;
    req_producer = '0;
    req_ksvc     = '0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    rx_q.delete();
    rx_cyc.delete();
    m_next_id = 0;
    ack_wait  = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge clk);
    clear_model();
    rst_n = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge
  task automatic push(input logic [1:0] svc, input logic [31:0] pl, input logic [15:0] tg,
                      input logic [15:0] pr, input logic [7:0] ks);
    int t = 0;
    req_valid    = 1'b1;
    req_service  = svc;
    req_payload  = pl;
    req_target   = tg;
    req_producer = pr;
    req_ksvc     = ks;
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL push_timeout: req_ready=%b after %0d cycles, required 1", req_ready, t);
    end else begin
      @(negedge clk);
      model_accept(svc, pl, tg, pr, ks);
    end
    req_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [1:0] svc);
    push(svc, $urandom, 16'($urandom), 16'($urandom), 8'($urandom));
  endtask

  task automatic wait_rx(input int n, input string name);
    int t = 0;
    while (rx_q.size() < n && t < 600) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rx_q.size() < n)
      $display("FAIL %s_timeout: packets=%0d, required %0d", name, rx_q.size(), n);
    else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    ack_mode = 0;
    rst_n    = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    n_checks++;
    if (br_req !== 1'b0 || br_data !== '0 || err !== 1'b0 || pending !== 3'd0)
      $display("FAIL reset_state: req=%b data=%h err=%b pending=%0d, required 0/0/0/0",
               br_req, br_data, err, pending);
    else n_pass++;
    clear_model();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || br_req !== 1'b0)
      $display("FAIL reset_release: ready=%b req=%b, required 1/0", req_ready, br_req);
    else n_pass++;

    repeat (4) push_rand(BR_SVC_ALL);
    n_checks++;
    if (pending !== 3'd3 || br_req !== 1'b1)
      $display("FAIL reset_presend: pending=%0d req=%b, required 3/1", pending, br_req);
    else n_pass++;

    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (br_req !== 1'b0 || pending !== 3'd0 || br_data !== '0)
      $display("FAIL reset_midsend: req=%b pending=%0d data=%h, required 0/0/0",
               br_req, pending, br_data);
    else n_pass++;
    @(negedge clk);
    clear_model();
    ack_mode = 1;
    rst_n    = 1'b1;
    @(negedge clk);

    push_rand(BR_SVC_ALL);
    wait_rx(1, "reset_after");
    repeat (4) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 1 || rx_q[0] !== exp_q[0] || rx_q[0].id !== 5'd0)
      $display("FAIL reset_next_pkt: count=%0d pkt=%h, required 1 pkt %h",
               rx_q.size(), rx_q.size() > 0 ? rx_q[0] : '0, exp_q[0]);
    else n_pass++;
  endtask

  task automatic test_single_all();
    do_reset();
    ack_mode     = 1;
    @(negedge clk);
    req_valid    = 1'b1;
    req_service  = BR_SVC_ALL;
    req_payload  = 32'hDEADBEEF;
    req_target   = 16'($urandom);
    req_producer = 16'($urandom);
    req_ksvc     = 8'h11;
    @(negedge clk);
    req_valid = 1'b0;
    model_accept(req_service, req_payload, req_target, req_producer, req_ksvc);
    n_checks++;
    if (br_req !== 1'b0 || pending !== 3'd1 || err !== 1'b0)
      $display("FAIL single_edge1: req=%b pending=%0d err=%b, required 0/1/0", br_req, pending, err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (br_req !== 1'b1 || br_data !== exp_q[0] || pending !== 3'd0)
      $display("FAIL single_edge2: req=%b data=%h pending=%0d, required 1 %h 0",
               br_req, br_data, pending, exp_q[0]);
    else n_pass++;
    n_checks++;
    if (br_data.source !== 16'h0102 || br_data.id !== 5'd0 || br_data.service !== BR_SVC_ALL)
      $display("FAIL single_fields: source=%h id=%0d svc=%0d, required 0102/0/0",
               br_data.source, br_data.id, br_data.service);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (br_req !== 1'b0 || rx_q.size() != 1)
      $display("FAIL single_done: req=%b packets=%0d, required 0/1", br_req, rx_q.size());
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [31:0] pl;
    logic [15:0] tg;
    do_reset();
    ack_mode = 0;
    @(negedge clk);
    repeat (5) push_rand(2'($urandom_range(0, 1)));
    n_checks++;
    if (pending !== 3'd4 || req_ready !== 1'b0 || br_req !== 1'b1 || br_data !== exp_q[0])
      $display("FAIL fill_full: pending=%0d ready=%b req=%b data=%h, required 4/0/1 %h",
               pending, req_ready, br_req, br_data, exp_q[0]);
    else n_pass++;

    pl = $urandom;
    tg = 16'($urandom);
    req_valid   = 1'b1;
    req_service = BR_SVC_TGT;
    req_payload = pl;
    req_target  = tg;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pending !== 3'd4 || req_ready !== 1'b0 || rx_q.size() != 0)
      $display("FAIL fill_held: pending=%0d ready=%b packets=%0d, required 4/0/0",
               pending, req_ready, rx_q.size());
    else n_pass++;

    ack_mode = 2;
    push(BR_SVC_TGT, pl, tg, 16'h00AB, 8'h5A);
    wait_rx(6, "fill");
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
        $display("FAIL fill_pkt[%0d]: got %h, required %h", i,
                 i < rx_q.size() ? rx_q[i] : '0, exp_q[i]);
      else n_pass++;
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (pending !== 3'd0 || req_ready !== 1'b1 || rx_q.size() != 6)
      $display("FAIL fill_drain: pending=%0d ready=%b packets=%0d, required 0/1/6",
               pending, req_ready, rx_q.size());
    else n_pass++;
  endtask

  task automatic test_id_wrap();
    do_reset();
    ack_mode = 2;
    @(negedge clk);
    for (int i = 0; i < 33; i++) push_rand(2'($urandom_range(0, 1)));
    wait_rx(33, "wrap");
    repeat (6) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 33)
      $display("FAIL wrap_count: packets=%0d, required 33", rx_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i])
        $display("FAIL wrap_pkt[%0d]: got %h, required %h", i,
                 i < rx_q.size() ? rx_q[i] : '0, exp_q[i]);
      else n_pass++;
    end
    if (rx_q.size() >= 33) begin
      n_checks++;
      if (rx_q[31].id !== 5'd31 || rx_q[32].id !== 5'd0)
        $display("FAIL wrap_ids: id31=%0d id32=%0d, required 31/0", rx_q[31].id, rx_q[32].id);
      else n_pass++;
    end
  endtask

  task automatic test_reject();
    logic [1:0] bad [2];
    bad[0] = BR_SVC_CLEAR;
    bad[1] = BR_SVC_RSV;
    do_reset();
    ack_mode = 1;
    @(negedge clk);
    req_valid   = 1'b1;
    req_service = BR_SVC_CLEAR;
    req_payload = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1 || pending !== 3'd0)
      $display("FAIL reject_empty: err=%b pending=%0d, required 1/0", err, pending);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || br_req !== 1'b0)
        $display("FAIL reject_quiet[%0d]: err=%b req=%b, required 0/0", i, err, br_req);
      else n_pass++;
    end

    ack_mode = 0;
    push_rand(BR_SVC_ALL);
    push_rand(BR_SVC_TGT);
    for (int k = 0; k < 2; k++) begin
      req_valid   = 1'b1;
      req_service = bad[k];
      req_payload = $urandom;
      @(negedge clk);
      req_valid = 1'b0;
      n_checks++;
      if (err !== 1'b1 || pending !== 3'd1 || br_data !== exp_q[0])
        $display("FAIL reject_busy[%0d]: err=%b pending=%0d data=%h, required 1/1 %h",
                 k, err, pending, br_data, exp_q[0]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || pending !== 3'd1)
        $display("FAIL reject_pulse[%0d]: err=%b pending=%0d, required 0/1", k, err, pending);
      else n_pass++;
    end

    ack_mode = 1;
    wait_rx(2, "reject");
    repeat (4) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 2 || rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1])
      $display("FAIL reject_stream: packets=%0d, required 2 with ids 0,1", rx_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ack_mode = 1;
    @(negedge clk);
    for (int i = 1; i <= 3; i++)
      push(BR_SVC_TGT, $urandom, 16'(i), 16'($urandom), 8'($urandom));
    wait_rx(3, "b2b");
    repeat (6) @(negedge clk);
    n_checks++;
    if (rx_q.size() != 3)
      $display("FAIL b2b_count: packets=%0d, required 3", rx_q.size());
    else n_pass++;
    if (rx_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (rx_q[i].target !== 16'(i + 1) || rx_q[i] !== exp_q[i])
          $display("FAIL b2b_order[%0d]: target=%h, required %h", i, rx_q[i].target, 16'(i + 1));
        else n_pass++;
      end
      for (int i = 1; i < 3; i++) begin
        n_checks++;
        if (rx_cyc[i] - rx_cyc[i-1] != 2)
          $display("FAIL b2b_spacing[%0d]: %0d cycles, required 2", i, rx_cyc[i] - rx_cyc[i-1]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    br_ack = 1'b0;
    drive_idle();
    test_reset();
    test_single_all();
    test_fill();
    test_id_wrap();
    test_reject();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
